// File: rtl/mem_arbiter.sv
// Round-robin arbiter that shares one memory read port and one memory write port
// among NUM_CONSUMERS requesters, serving one transaction at a time.
module mem_arbiter #(
  parameter int NUM_CONSUMERS = 4,
  parameter int ADDR_BITS     = 8,
  parameter int DATA_BITS     = 16
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [NUM_CONSUMERS-1:0]            consumer_read_valid,
  input  logic [NUM_CONSUMERS*ADDR_BITS-1:0]  consumer_read_address,
  output logic [NUM_CONSUMERS-1:0]            consumer_read_ready,
  output logic [NUM_CONSUMERS*DATA_BITS-1:0]  consumer_read_data,
  input  logic [NUM_CONSUMERS-1:0]            consumer_write_valid,
  input  logic [NUM_CONSUMERS*ADDR_BITS-1:0]  consumer_write_address,
  input  logic [NUM_CONSUMERS*DATA_BITS-1:0]  consumer_write_data,
  output logic [NUM_CONSUMERS-1:0]            consumer_write_ready,
  output logic                                mem_read_valid,
  output logic [ADDR_BITS-1:0]                mem_read_address,
  input  logic                                mem_read_ready,
  input  logic [DATA_BITS-1:0]                mem_read_data,
  output logic                                mem_write_valid,
  output logic [ADDR_BITS-1:0]                mem_write_address,
  output logic [DATA_BITS-1:0]                mem_write_data,
  input  logic                                mem_write_ready
);

  localparam int IDX_W = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;

  typedef enum logic [2:0] {
    IDLE           = 3'd0,
    READ_WAITING   = 3'd1,
    WRITE_WAITING  = 3'd2,
    READ_RELAYING  = 3'd3,
    WRITE_RELAYING = 3'd4
  } state_t;

  state_t           state, state_next;
  logic [IDX_W-1:0] grant, grant_next;
  logic [IDX_W-1:0] rr_ptr, rr_ptr_next;

  logic [NUM_CONSUMERS-1:0] req;
  logic                     req_any;
  logic [IDX_W-1:0]         sel_idx;
  logic [IDX_W-1:0]         sel_plus1;
  logic                     sel_is_read;

  logic                               mem_read_valid_next;
  logic [ADDR_BITS-1:0]               mem_read_address_next;
  logic                               mem_write_valid_next;
  logic [ADDR_BITS-1:0]               mem_write_address_next;
  logic [DATA_BITS-1:0]               mem_write_data_next;
  logic [NUM_CONSUMERS-1:0]           consumer_read_ready_next;
  logic [NUM_CONSUMERS-1:0]           consumer_write_ready_next;
  logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_read_data_next;

  assign req = consumer_read_valid | consumer_write_valid;

  // Scan downward so the candidate closest to rr_ptr (smallest offset) wins.
  always_comb begin
    req_any = 1'b0;
    sel_idx = '0;
    for (int k = NUM_CONSUMERS - 1; k >= 0; k--) begin
      if (req[(int'(rr_ptr) + k) % NUM_CONSUMERS]) begin
        req_any = 1'b1;
        sel_idx = IDX_W'((int'(rr_ptr) + k) % NUM_CONSUMERS);
      end
    end
  end

  assign sel_is_read = consumer_read_valid[sel_idx];
  assign sel_plus1   = (sel_idx == IDX_W'(NUM_CONSUMERS - 1)) ? '0 : sel_idx + 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      grant  <= '0;
      rr_ptr <= '0;
    end else begin
      state  <= state_next;
      grant  <= grant_next;
      rr_ptr <= rr_ptr_next;
    end
  end

  always_comb begin
    state_next  = state;
    grant_next  = grant;
    rr_ptr_next = rr_ptr;
    case (state)
      IDLE: begin
        if (req_any) begin
          grant_next  = sel_idx;
          rr_ptr_next = sel_plus1;
          state_next  = sel_is_read ? READ_WAITING : WRITE_WAITING;
        end
      end
      READ_WAITING: begin
        if (mem_read_ready) state_next = READ_RELAYING;
      end
      WRITE_WAITING: begin
        if (mem_write_ready) state_next = WRITE_RELAYING;
      end
      READ_RELAYING: begin
        if (!consumer_read_valid[grant]) state_next = IDLE;
      end
      WRITE_RELAYING: begin
        if (!consumer_write_valid[grant]) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Outputs are registered: this block computes their values for the next edge.
  always_comb begin
    mem_read_valid_next       = mem_read_valid;
    mem_read_address_next     = mem_read_address;
    mem_write_valid_next      = mem_write_valid;
    mem_write_address_next    = mem_write_address;
    mem_write_data_next       = mem_write_data;
    consumer_read_ready_next  = consumer_read_ready;
    consumer_write_ready_next = consumer_write_ready;
    consumer_read_data_next   = consumer_read_data;
    case (state)
      IDLE: begin
        if (req_any) begin
          if (sel_is_read) begin
            mem_read_valid_next   = 1'b1;
            mem_read_address_next = consumer_read_address[int'(sel_idx)*ADDR_BITS +: ADDR_BITS];
          end else begin
            mem_write_valid_next   = 1'b1;
            mem_write_address_next = consumer_write_address[int'(sel_idx)*ADDR_BITS +: ADDR_BITS];
            mem_write_data_next    = consumer_write_data[int'(sel_idx)*DATA_BITS +: DATA_BITS];
          end
        end
      end
      READ_WAITING: begin
        if (mem_read_ready) begin
          mem_read_valid_next = 1'b0;
          consumer_read_data_next[int'(grant)*DATA_BITS +: DATA_BITS] = mem_read_data;
          consumer_read_ready_next[grant] = 1'b1;
        end
      end
      WRITE_WAITING: begin
        if (mem_write_ready) begin
          mem_write_valid_next = 1'b0;
          consumer_write_ready_next[grant] = 1'b1;
        end
      end
      READ_RELAYING: begin
        if (!consumer_read_valid[grant]) consumer_read_ready_next[grant] = 1'b0;
      end
      WRITE_RELAYING: begin
        if (!consumer_write_valid[grant]) consumer_write_ready_next[grant] = 1'b0;
      end
      default: begin
        mem_read_valid_next       = 1'b0;
        mem_write_valid_next      = 1'b0;
        consumer_read_ready_next  = '0;
        consumer_write_ready_next = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_read_valid       <= 1'b0;
      mem_read_address     <= '0;
      mem_write_valid      <= 1'b0;
      mem_write_address    <= '0;
      mem_write_data       <= '0;
      consumer_read_ready  <= '0;
      consumer_write_ready <= '0;
      consumer_read_data   <= '0;
    end else begin
      mem_read_valid       <= mem_read_valid_next;
      mem_read_address     <= mem_read_address_next;
      mem_write_valid      <= mem_write_valid_next;
      mem_write_address    <= mem_write_address_next;
      mem_write_data       <= mem_write_data_next;
      consumer_read_ready  <= consumer_read_ready_next;
      consumer_write_ready <= consumer_write_ready_next;
      consumer_read_data   <= consumer_read_data_next;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: transaction-level reference model compared every cycle,
// directed scenarios with literal expectations, then a randomized phase.
module tb_mem_arbiter;
  localparam int N  = 4;
  localparam int AW = 8;
  localparam int DW = 16;

  logic          clk   = 1'b0;
  logic          reset = 1'b1;
  logic [N-1:0]    rv  = '0;
  logic [N-1:0]    wv  = '0;
  logic [N*AW-1:0] cra = '0;
  logic [N*AW-1:0] cwa = '0;
  logic [N*DW-1:0] cwd = '0;
  logic [N-1:0]    consumer_read_ready;
  logic [N-1:0]    consumer_write_ready;
  logic [N*DW-1:0] consumer_read_data;
  logic            mem_read_valid, mem_write_valid;
  logic [AW-1:0]   mem_read_address, mem_write_address;
  logic [DW-1:0]   mem_write_data;
  logic            mem_read_ready  = 1'b1;
  logic            mem_write_ready = 1'b1;
  logic [DW-1:0]   mem_read_data   = '0;

  always #5 clk = ~clk;

  mem_arbiter #(.NUM_CONSUMERS(N), .ADDR_BITS(AW), .DATA_BITS(DW)) dut (
    .clk                    (clk),
    .reset                  (reset),
    .consumer_read_valid    (rv),
    .consumer_read_address  (cra),
    .consumer_read_ready    (consumer_read_ready),
    .consumer_read_data     (consumer_read_data),
    .consumer_write_valid   (wv),
    .consumer_write_address (cwa),
    .consumer_write_data    (cwd),
    .consumer_write_ready   (consumer_write_ready),
    .mem_read_valid         (mem_read_valid),
    .mem_read_address       (mem_read_address),
    .mem_read_ready         (mem_read_ready),
    .mem_read_data          (mem_read_data),
    .mem_write_valid        (mem_write_valid),
    .mem_write_address      (mem_write_address),
    .mem_write_data         (mem_write_data),
    .mem_write_ready        (mem_write_ready)
  );

  int checks   = 0;
  int failures = 0;
  bit cmp_en = 0, rand_mode = 0, rand_mem = 0, persist = 0;
  bit rd_hold = 0, wr_hold = 0, fixed_rd = 1;
  bit prev_mrv = 0, prev_mwv = 0;
  logic [31:0] log_q[$];

  // Reference model: one outstanding transaction, described by owner/kind/phase.
  bit              m_busy = 0, m_wr = 0, m_relay = 0;
  int              m_owner = 0, m_rr = 0;
  logic            exp_mrv = 0, exp_mwv = 0;
  logic [AW-1:0]   exp_mra = '0, exp_mwa = '0;
  logic [DW-1:0]   exp_mwd = '0;
  logic [N-1:0]    exp_rrdy = '0, exp_wrdy = '0;
  logic [N*DW-1:0] exp_rdata = '0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_step();
    int pick;
    pick = -1;
    if (!m_busy) begin
      for (int k = 0; k < N; k++)
        if (pick < 0 && (rv[(m_rr + k) % N] || wv[(m_rr + k) % N])) pick = (m_rr + k) % N;
      if (pick >= 0) begin
        m_busy = 1; m_owner = pick; m_relay = 0; m_wr = !rv[pick];
        m_rr = (pick + 1) % N;
        if (!m_wr) begin
          exp_mrv = 1'b1; exp_mra = cra[pick*AW +: AW];
        end else begin
          exp_mwv = 1'b1; exp_mwa = cwa[pick*AW +: AW]; exp_mwd = cwd[pick*DW +: DW];
        end
      end
    end else if (!m_relay) begin
      if (!m_wr && mem_read_ready) begin
        exp_mrv = 1'b0; exp_rrdy[m_owner] = 1'b1;
        exp_rdata[m_owner*DW +: DW] = mem_read_data; m_relay = 1;
      end else if (m_wr && mem_write_ready) begin
        exp_mwv = 1'b0; exp_wrdy[m_owner] = 1'b1; m_relay = 1;
      end
    end else if (m_wr ? !wv[m_owner] : !rv[m_owner]) begin
      exp_rrdy[m_owner] = 1'b0; exp_wrdy[m_owner] = 1'b0; m_busy = 0;
    end
  endtask

  initial begin
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        m_busy = 0; m_rr = 0; m_relay = 0; exp_mrv = 0; exp_mwv = 0;
        exp_mra = '0; exp_mwa = '0; exp_mwd = '0;
        exp_rrdy = '0; exp_wrdy = '0; exp_rdata = '0;
      end else begin
        model_step();
      end
    end
  end

  initial begin
    wait (cmp_en);
    forever begin
      @(negedge clk);
      chk("mem_read_valid", 64'(mem_read_valid), 64'(exp_mrv));
      if (exp_mrv) chk("mem_read_address", 64'(mem_read_address), 64'(exp_mra));
      chk("mem_write_valid", 64'(mem_write_valid), 64'(exp_mwv));
      if (exp_mwv) begin
        chk("mem_write_address", 64'(mem_write_address), 64'(exp_mwa));
        chk("mem_write_data", 64'(mem_write_data), 64'(exp_mwd));
      end
      chk("read_ready", 64'(consumer_read_ready), 64'(exp_rrdy));
      chk("write_ready", 64'(consumer_write_ready), 64'(exp_wrdy));
      chk("read_data", 64'(consumer_read_data), 64'(exp_rdata));
      chk("mem_valid_exclusive", 64'(mem_read_valid & mem_write_valid), 64'h0);
    end
  end

  task automatic tick();
    @(negedge clk);
    if (mem_read_valid && !prev_mrv) log_q.push_back({8'h00, mem_read_address, 16'h0000});
    if (mem_write_valid && !prev_mwv) log_q.push_back({8'h01, mem_write_address, mem_write_data});
    prev_mrv = mem_read_valid;
    prev_mwv = mem_write_valid;
    for (int i = 0; i < N; i++) begin
      if (rv[i] && consumer_read_ready[i]) rv[i] = 1'b0;
      else if (persist && !rv[i] && !consumer_read_ready[i]) rv[i] = 1'b1;
      else if (rand_mode && !rv[i] && !consumer_read_ready[i] && $urandom_range(99) < 15) begin
        rv[i] = 1'b1; cra[i*AW +: AW] = AW'($urandom);
      end else if (rand_mode && rv[i] && $urandom_range(99) < 2) rv[i] = 1'b0;
      if (wv[i] && consumer_write_ready[i]) wv[i] = 1'b0;
      else if (rand_mode && !wv[i] && !consumer_write_ready[i] && $urandom_range(99) < 15) begin
        wv[i] = 1'b1; cwa[i*AW +: AW] = AW'($urandom); cwd[i*DW +: DW] = DW'($urandom);
      end else if (rand_mode && wv[i] && $urandom_range(99) < 2) wv[i] = 1'b0;
    end
    mem_read_ready  = rd_hold ? 1'b0 : (rand_mem ? ($urandom_range(99) < 60) : 1'b1);
    mem_write_ready = wr_hold ? 1'b0 : (rand_mem ? ($urandom_range(99) < 60) : 1'b1);
    mem_read_data   = fixed_rd ? 16'hBEEF : DW'($urandom);
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_log(input int n, input int budget);
    int c = 0;
    while (log_q.size() < n && c < budget) begin
      tick();
      c++;
    end
    if (log_q.size() < n) chk("wait_timeout", 64'(log_q.size()), 64'(n));
  endtask

  task automatic chk_log(input int i, input logic [31:0] exp);
    logic [31:0] act;
    act = (log_q.size() > i) ? log_q[i] : 32'hFFFF_FFFF;
    chk($sformatf("issue_order[%0d]", i), 64'(act), 64'(exp));
  endtask

  task automatic do_reset();
    reset = 1'b1; rv = '0; wv = '0; persist = 0;
    tick_n(2);
    reset = 1'b0;
  endtask

  // Assert reset between clock edges and confirm outputs clear without waiting for clk.
  task automatic mid_reset();
    #3;
    reset = 1'b1; rv = '0; wv = '0;
    #1;
    chk("async_rst_mem_read_valid", 64'(mem_read_valid), 64'h0);
    chk("async_rst_mem_write_valid", 64'(mem_write_valid), 64'h0);
    chk("async_rst_read_ready", 64'(consumer_read_ready), 64'h0);
    chk("async_rst_read_data", 64'(consumer_read_data), 64'h0);
    chk("async_rst_mem_read_address", 64'(mem_read_address), 64'h0);
    tick();
    reset = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b0;
    cmp_en = 1;
    tick();
    chk("reset_mem_read_valid", 64'(mem_read_valid), 64'h0);
    chk("reset_mem_write_valid", 64'(mem_write_valid), 64'h0);
    chk("reset_ready", 64'({consumer_read_ready, consumer_write_ready}), 64'h0);
    chk("reset_read_data", 64'(consumer_read_data), 64'h0);

    // Single read from consumer 2.
    cra[2*AW +: AW] = 8'h10; rv[2] = 1'b1;
    tick();
    chk("single_mem_read_valid", 64'(mem_read_valid), 64'h1);
    chk("single_mem_read_address", 64'(mem_read_address), 64'h10);
    tick();
    chk("single_read_ready", 64'(consumer_read_ready), 64'h4);
    chk("single_read_data2", 64'(consumer_read_data[2*DW +: DW]), 64'hBEEF);
    tick();
    chk("single_ready_cleared", 64'(consumer_read_ready), 64'h0);
    chk("single_data_kept", 64'(consumer_read_data[2*DW +: DW]), 64'hBEEF);
    tick_n(2);

    // Wrap fairness: pointer sits at 3 after serving consumer 2.
    log_q.delete();
    cra[0*AW +: AW] = 8'h50; cra[3*AW +: AW] = 8'h53; rv[0] = 1'b1; rv[3] = 1'b1;
    wait_log(2, 40);
    chk_log(0, 32'h0053_0000);
    chk_log(1, 32'h0050_0000);
    tick_n(8);

    // Consumer 1 reads and writes together: read goes first.
    log_q.delete();
    cra[1*AW +: AW] = 8'h21; cwa[1*AW +: AW] = 8'h22; cwd[1*DW +: DW] = 16'h1234;
    rv[1] = 1'b1; wv[1] = 1'b1;
    wait_log(2, 40);
    chk_log(0, 32'h0021_0000);
    chk_log(1, 32'h0122_1234);
    tick_n(8);

    // Write stall: consumer 3's read must wait behind consumer 2's stalled write.
    log_q.delete();
    wr_hold = 1; mem_write_ready = 1'b0;
    cwa[2*AW +: AW] = 8'h30; cwd[2*DW +: DW] = 16'hAAAA; wv[2] = 1'b1;
    cra[3*AW +: AW] = 8'h33; rv[3] = 1'b1;
    wait_log(1, 20);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("stall_write_valid", 64'(mem_write_valid), 64'h1);
      chk("stall_write_address", 64'(mem_write_address), 64'h30);
      chk("stall_no_read", 64'(mem_read_valid), 64'h0);
      chk("stall_no_ready", 64'({consumer_read_ready, consumer_write_ready}), 64'h0);
    end
    wr_hold = 0; mem_write_ready = 1'b1;
    wait_log(2, 40);
    chk_log(0, 32'h0130_AAAA);
    chk_log(1, 32'h0033_0000);
    tick_n(8);

    // Round robin from reset with all consumers reading continuously.
    do_reset();
    for (int i = 0; i < N; i++) cra[i*AW +: AW] = 8'h40 + 8'(i);
    log_q.delete();
    persist = 1;
    wait_log(5, 80);
    persist = 0; rv = '0;
    for (int i = 0; i < 5; i++) chk_log(i, {8'h00, 8'h40 + 8'(i % 4), 16'h0000});
    tick_n(10);

    // Randomized traffic with a reset dropped in mid-run.
    rand_mode = 1; rand_mem = 1; fixed_rd = 0;
    tick_n(1500);
    mid_reset();
    tick_n(1500);
    rand_mode = 0; rand_mem = 0; rv = '0; wv = '0;
    tick_n(20);

    // Reset while a read is outstanding, then arbitration restarts at consumer 0.
    log_q.delete();
    rd_hold = 1; mem_read_ready = 1'b0;
    cra[1*AW +: AW] = 8'h71; rv[1] = 1'b1;
    wait_log(1, 20);
    tick();
    mid_reset();
    rd_hold = 0; mem_read_ready = 1'b1;
    log_q.delete();
    cra[0*AW +: AW] = 8'h60; cra[3*AW +: AW] = 8'h63; rv[0] = 1'b1; rv[3] = 1'b1;
    wait_log(2, 40);
    chk_log(0, 32'h0060_0000);
    chk_log(1, 32'h0063_0000);
    tick_n(10);

    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
